// File: rtl/tp2_pkg.sv
// -----------------------------------------------------------------------------
// tp2_pkg
// Shared definitions for the ALU-over-UART block:
//   - command bytes recognised by the command FSM
//   - ALU opcodes (MIPS funct-style encoding)
//   - bit positions inside the flags byte {4'b0, N, V, C, Z}
//   - command-FSM state type
//   - baud divisor helper used by the UART
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package tp2_pkg;

    // Command bytes
    localparam logic [7:0] CMD_CONFIG  = 8'hCD;
    localparam logic [7:0] CMD_DISPLAY = 8'hD1;

    // ALU opcodes
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;

    // Flag bit positions in the flags byte
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_A,
        ST_GET_B,
        ST_GET_OP,
        ST_SEND_RES,
        ST_SEND_FLAGS
    } cmd_state_t;

    // Clocks per oversample tick, truncated.
    function automatic int baud_divisor(input int clk_hz, input int baud, input int os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/tp2_uart.sv
// -----------------------------------------------------------------------------
// tp2_uart
// 8N1 UART: free-running oversample tick generator, receiver and transmitter.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset (already release-synchronised)
//   i_rx         in   serial input, idle high
//   o_rx_data    out  received byte, valid while o_rx_valid is high
//   o_rx_valid   out  one-cycle pulse for each byte with a good stop bit
//   i_tx_data    in   byte to transmit, sampled when i_tx_start is accepted
//   i_tx_start   in   request to send i_tx_data (accepted only when idle)
//   o_tx_busy    out  high from the load request until the end of the stop bit
//   o_tx         out  serial output, idle high
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tp2_uart
    import tp2_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam int DIVISOR = baud_divisor(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int OS_W    = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_baud_cnt;
    logic             r_tick;

    // NOTE: sequential state is written with <= so every register in the
    // design samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_baud_cnt == DIV_LAST) begin
            r_baud_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_baud_cnt <= r_baud_cnt + DIV_W'(1);
            r_tick     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]      r_rx_sync;
    logic            r_rx_prev;
    rx_state_t       r_rx_state;
    logic [OS_W-1:0] r_rx_tick_cnt;
    logic [2:0]      r_rx_bit_idx;
    logic [7:0]      r_rx_shift;
    logic            r_rx_valid;
    logic            w_rx;
    logic            w_rx_fall;

    // Reset to the idle level so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], i_rx};
            r_rx_prev <= r_rx_sync[1];
        end
    end

    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev & ~w_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state    <= RX_IDLE;
            r_rx_tick_cnt <= '0;
            r_rx_bit_idx  <= '0;
            r_rx_shift    <= '0;
            r_rx_valid    <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_state    <= RX_START;
                        r_rx_tick_cnt <= '0;
                    end
                end
                RX_START: begin
                    if (r_tick) begin
                        if (r_rx_tick_cnt == OS_HALF) begin
                            // Mid start bit: a high line here was only a glitch.
                            r_rx_state    <= w_rx ? RX_IDLE : RX_DATA;
                            r_rx_tick_cnt <= '0;
                            r_rx_bit_idx  <= '0;
                        end else begin
                            r_rx_tick_cnt <= r_rx_tick_cnt + OS_W'(1);
                        end
                    end
                end
                RX_DATA: begin
                    if (r_tick) begin
                        if (r_rx_tick_cnt == OS_LAST) begin
                            r_rx_tick_cnt <= '0;
                            r_rx_shift    <= {w_rx, r_rx_shift[7:1]};
                            if (r_rx_bit_idx == 3'd7) begin
                                r_rx_state <= RX_STOP;
                            end else begin
                                r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                            end
                        end else begin
                            r_rx_tick_cnt <= r_rx_tick_cnt + OS_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (r_tick) begin
                        if (r_rx_tick_cnt == OS_LAST) begin
                            // Low stop bit is a framing error: byte is dropped.
                            r_rx_valid <= w_rx;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_tick_cnt <= r_rx_tick_cnt + OS_W'(1);
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign o_rx_data  = r_rx_shift;
    assign o_rx_valid = r_rx_valid;

    // ------------------------------------------------------------------
    // Transmitter
    // r_tx_bit_cnt counts bits already completed: 0 = start bit on the
    // line, 1..8 = data bit (cnt-1), 9 = stop bit.
    // ------------------------------------------------------------------
    logic            r_tx_busy;
    logic            r_tx_out;
    logic [7:0]      r_tx_shift;
    logic [3:0]      r_tx_bit_cnt;
    logic [OS_W-1:0] r_tx_tick_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy     <= 1'b0;
            r_tx_out      <= 1'b1;
            r_tx_shift    <= '0;
            r_tx_bit_cnt  <= '0;
            r_tx_tick_cnt <= '0;
        end else if (!r_tx_busy) begin
            if (i_tx_start) begin
                r_tx_busy     <= 1'b1;
                r_tx_out      <= 1'b0;
                r_tx_shift    <= i_tx_data;
                r_tx_bit_cnt  <= '0;
                r_tx_tick_cnt <= '0;
            end
        end else if (r_tick) begin
            if (r_tx_tick_cnt == OS_LAST) begin
                r_tx_tick_cnt <= '0;
                if (r_tx_bit_cnt == 4'd9) begin
                    r_tx_busy <= 1'b0;
                end else begin
                    r_tx_bit_cnt <= r_tx_bit_cnt + 4'd1;
                    if (r_tx_bit_cnt == 4'd8) begin
                        r_tx_out <= 1'b1;
                    end else begin
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end
                end
            end else begin
                r_tx_tick_cnt <= r_tx_tick_cnt + OS_W'(1);
            end
        end
    end

    // Busy covers the request cycle too, so a requester never sees a gap
    // between issuing tx_start and the transmitter registering it.
    assign o_tx_busy = r_tx_busy | i_tx_start;
    assign o_tx      = r_tx_out;

endmodule

// File: rtl/tp2_top.sv
// -----------------------------------------------------------------------------
// tp2_top
// Board-level top of the ALU-over-UART block. A command FSM parses bytes from
// the UART: CONFIG (0xCD) loads A, B and an opcode and registers the ALU
// result and flags; DISPLAY (0xD1) sends the result byte then the flags byte.
// The last result is shown on LEDS.
//
// Ports:
//   CLK100MHZ   in   system clock, rising edge
//   BTN_CENTER  in   reset, asynchronous active-low
//   RX_IN       in   UART serial input, idle high
//   TX_OUT      out  UART serial output, idle high
//   LEDS        out  last ALU result
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tp2_top
    import tp2_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK100MHZ,
    input  logic       BTN_CENTER,
    input  logic       RX_IN,
    output logic       TX_OUT,
    output logic [7:0] LEDS
);

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge.
    // ------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK100MHZ or negedge BTN_CENTER) begin
        if (!BTN_CENTER) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ------------------------------------------------------------------
    // UART
    // ------------------------------------------------------------------
    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_tx_busy;
    logic       w_tx;
    logic [7:0] r_tx_data;
    logic       r_tx_start;

    tp2_uart #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_uart (
        .clk        (CLK100MHZ),
        .rst_n      (w_rst_n),
        .i_rx       (RX_IN),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .i_tx_data  (r_tx_data),
        .i_tx_start (r_tx_start),
        .o_tx_busy  (w_tx_busy),
        .o_tx       (w_tx)
    );

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    cmd_state_t r_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_op;
    logic [7:0] r_result;
    logic [7:0] r_flags;
    logic       r_issued;

    logic [7:0] w_alu_op;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_alu_result;
    logic [7:0] w_alu_flags;
    logic       w_carry;
    logic       w_ovf;
    logic       w_op_known;

    // The opcode byte arriving in GET_OP is evaluated directly so result and
    // flags can be registered in the same cycle it is received.
    assign w_alu_op = (r_state == ST_GET_OP) ? w_rx_data : r_op;

    // Bit 8 of the 9-bit sum is the carry; of the difference, the borrow (A<B).
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    // NOTE: every output of this block is assigned a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_alu_result = 8'h00;
        w_carry      = 1'b0;
        w_ovf        = 1'b0;
        w_op_known   = 1'b1;
        case (w_alu_op)
            OP_ADD: begin
                w_alu_result = w_sum[7:0];
                w_carry      = w_sum[8];
                w_ovf        = (r_a[7] == r_b[7]) && (w_sum[7] != r_a[7]);
            end
            OP_SUB: begin
                w_alu_result = w_diff[7:0];
                w_carry      = w_diff[8];
                w_ovf        = (r_a[7] != r_b[7]) && (w_diff[7] != r_a[7]);
            end
            OP_AND: w_alu_result = r_a & r_b;
            OP_OR:  w_alu_result = r_a | r_b;
            OP_XOR: w_alu_result = r_a ^ r_b;
            OP_NOR: w_alu_result = ~(r_a | r_b);
            OP_SRL: w_alu_result = r_a >> r_b[2:0];
            OP_SRA: w_alu_result = 8'($signed(r_a) >>> r_b[2:0]);
            default: w_op_known = 1'b0;
        endcase

        // An undefined opcode reports all-zero flags, Z included.
        w_alu_flags = 8'h00;
        if (w_op_known) begin
            w_alu_flags[FLAG_Z] = (w_alu_result == 8'h00);
            w_alu_flags[FLAG_C] = w_carry;
            w_alu_flags[FLAG_V] = w_ovf;
            w_alu_flags[FLAG_N] = w_alu_result[7];
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // In the SEND_* states r_issued separates "request not yet made" from
    // "waiting for the transmitter to finish the byte".
    // ------------------------------------------------------------------
    always_ff @(posedge CLK100MHZ or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_a        <= 8'h00;
            r_b        <= 8'h00;
            r_op       <= 8'h00;
            r_result   <= 8'h00;
            r_flags    <= 8'h00;
            r_issued   <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_valid) begin
                        if (w_rx_data == CMD_CONFIG) begin
                            r_state <= ST_GET_A;
                        end else if (w_rx_data == CMD_DISPLAY) begin
                            r_state  <= ST_SEND_RES;
                            r_issued <= 1'b0;
                        end
                    end
                end
                ST_GET_A: begin
                    if (w_rx_valid) begin
                        r_a     <= w_rx_data;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (w_rx_valid) begin
                        r_b     <= w_rx_data;
                        r_state <= ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (w_rx_valid) begin
                        r_op     <= w_rx_data;
                        r_result <= w_alu_result;
                        r_flags  <= w_alu_flags;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_SEND_RES: begin
                    if (!r_issued) begin
                        if (!w_tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_result;
                            r_issued   <= 1'b1;
                        end
                    end else if (!w_tx_busy) begin
                        r_state  <= ST_SEND_FLAGS;
                        r_issued <= 1'b0;
                    end
                end
                ST_SEND_FLAGS: begin
                    if (!r_issued) begin
                        if (!w_tx_busy) begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_flags;
                            r_issued   <= 1'b1;
                        end
                    end else if (!w_tx_busy) begin
                        r_state  <= ST_IDLE;
                        r_issued <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign TX_OUT = w_tx;
    assign LEDS   = r_result;

endmodule

// File: tb/tb_tp2_top.sv
// -----------------------------------------------------------------------------
// tb_tp2_top
// Directed bench for tp2_top. The baud rate is raised so one bit lasts 32
// clocks (divisor 2, 16 ticks per bit). Expected TX bytes are queued when a
// DISPLAY command is sent; a serial monitor decodes TX_OUT and pops/compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_tp2_top;

    localparam int BIT_CLKS = 32;  // 100 MHz clock, 3.125 Mbaud

    logic       clk     = 1'b0;
    logic       rst_btn = 1'b1;
    logic       rx      = 1'b1;
    logic       tx;
    logic [7:0] leds;

    int         checks    = 0;
    int         failures  = 0;
    int         tx_frames = 0;
    bit         mon_en    = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tp2_top #(
        .CLK_FREQ   (100_000_000),
        .BAUD_RATE  (3_125_000),
        .OVERSAMPLE (16)
    ) dut (
        .CLK100MHZ  (clk),
        .BTN_CENTER (rst_btn),
        .RX_IN      (rx),
        .TX_OUT     (tx),
        .LEDS       (leds)
    );

    // ------------------------------------------------------------------
    // Comparison helpers
    // ------------------------------------------------------------------
    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic do_config(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(8'hCD, 1'b1);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(op, 1'b1);
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_int({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic do_display(input string tag, input logic [7:0] res, input logic [7:0] flags);
        exp_q.push_back(res);
        exp_q.push_back(flags);
        send_byte(8'hD1, 1'b1);
        wait_drain(tag);
    endtask

    // ------------------------------------------------------------------
    // TX monitor / scoreboard consumer
    // ------------------------------------------------------------------
    initial begin : tx_monitor
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge tx);
            repeat (BIT_CLKS / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (BIT_CLKS) @(negedge clk);
                b[i] = tx;
            end
            repeat (BIT_CLKS) @(negedge clk);
            stop_bit = tx;
            if (mon_en) begin
                tx_frames++;
                check1("tx_stop_bit", stop_bit, 1'b1);
                check1("tx_byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check8("tx_byte", b, exp_q.pop_front());
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int frames_before;
        int n;

        #1 rst_btn = 1'b0;
        repeat (10) @(negedge clk);
        check1("reset_tx_idle", tx, 1'b1);
        check8("reset_leds", leds, 8'h00);
        rst_btn = 1'b1;
        repeat (10) @(negedge clk);
        check1("post_reset_tx_idle", tx, 1'b1);
        check8("post_reset_leds", leds, 8'h00);
        mon_en = 1'b1;

        do_display("disp_after_reset", 8'h00, 8'h00);

        do_config(8'h05, 8'h0A, 8'h20);
        check8("add_leds", leds, 8'h0F);
        do_display("disp_add", 8'h0F, 8'h00);

        do_config(8'h64, 8'h64, 8'h22);
        check8("sub_zero_leds", leds, 8'h00);
        do_display("disp_sub_zero", 8'h00, 8'h01);

        do_config(8'h64, 8'h32, 8'h20);
        check8("add_ovf_leds", leds, 8'h96);
        do_display("disp_add_ovf", 8'h96, 8'h0C);

        do_config(8'h03, 8'h05, 8'h22);
        check8("sub_borrow_leds", leds, 8'hFE);
        do_display("disp_sub_borrow", 8'hFE, 8'h0A);

        do_config(8'hF0, 8'h02, 8'h03);
        check8("sra_leds", leds, 8'hFC);
        do_display("disp_sra", 8'hFC, 8'h08);

        do_config(8'h81, 8'h09, 8'h02);  // only B[2:0]=1 is used
        check8("srl_leds", leds, 8'h40);

        do_config(8'hF0, 8'h3C, 8'h24);
        check8("and_leds", leds, 8'h30);

        do_config(8'h0F, 8'hF0, 8'h27);
        check8("nor_leds", leds, 8'h00);
        do_display("disp_nor", 8'h00, 8'h01);

        do_config(8'h12, 8'h34, 8'h3F);
        check8("undef_leds", leds, 8'h00);
        do_display("disp_undef", 8'h00, 8'h00);

        // Unrecognised byte in IDLE produces no transmission.
        frames_before = tx_frames;
        send_byte(8'h55, 1'b1);
        repeat (12 * BIT_CLKS) @(negedge clk);
        check_int("idle_ignore_frames", tx_frames, frames_before);
        check1("idle_ignore_tx_high", tx, 1'b1);
        do_config(8'h05, 8'h0A, 8'h20);
        check8("after_ignore_leds", leds, 8'h0F);

        // Framing error in GET_A: byte dropped, next good byte is A.
        send_byte(8'hCD, 1'b1);
        send_byte(8'h77, 1'b0);
        send_byte(8'h21, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        repeat (8) @(negedge clk);
        check8("framing_leds", leds, 8'h31);

        // 100 ns low glitch in GET_A: not taken as a byte.
        send_byte(8'hCD, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'h2C, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (8) @(negedge clk);
        check8("glitch_leds", leds, 8'h0B);
        do_display("disp_glitch", 8'h0B, 8'h00);

        // Reset in the middle of the result byte (0x0B: data bit 2 is low).
        mon_en = 1'b0;
        send_byte(8'hD1, 1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check1("midtx_started", tx, 1'b0);
        repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        rst_btn = 1'b0;
        #1;
        check1("midtx_reset_tx_idle", tx, 1'b1);
        check8("midtx_reset_leds", leds, 8'h00);
        repeat (5) @(negedge clk);
        rst_btn = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check1("after_midtx_tx_idle", tx, 1'b1);
        exp_q.delete();
        mon_en = 1'b1;
        do_display("disp_after_midtx_reset", 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tp2_top.md
Name: tp2_top

Overview:
FPGA top for the ALU-over-UART lab block. Receives 8N1 bytes on RX_IN and runs a command protocol: CONFIG loads operands A, B and an opcode and computes the result; DISPLAY returns the result and flags on TX_OUT. The last result is also driven on LEDS. One instance sits directly on board pins (100 MHz clock, centre button as reset).

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BAUD_RATE, 9600, UART bit rate.
OVERSAMPLE, 16, ticks per bit. Tick divisor = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), truncated (651), so one bit = 651*16 clocks.

Ports:
CLK100MHZ  in  1  system clock, rising edge.
BTN_CENTER  in  1  reset. Asynchronous, active-low.
RX_IN  in  1  UART serial input, idle high.
TX_OUT  out  1  UART serial output, idle high.
LEDS  out  8  last ALU result.

Behaviour:
- Reset (asynchronous assert, synchronous release): all FSMs go idle, A/B/op/result/flags clear to 0, LEDS=0, TX_OUT=1. A reset mid-frame aborts RX and TX with no partial output.
- Baud tick: counter from 0 to divisor-1, one-cycle tick pulse, free-running.
- RX:
  - Start is a 1->0 on RX_IN, with a 2-FF synchroniser first.
  - After 8 ticks, re-sample: if high, treat as a glitch and return idle.
  - Sample 8 data bits LSB first, 16 ticks apart, then the stop bit.
  - Stop=1 gives a one-cycle rx_valid with the byte. Stop=0 is a framing error; the byte is dropped.
- TX: start(0), 8 data bits LSB first, stop(1), 16 ticks per bit. tx_busy is high from load until the end of stop.
- Command FSM states: IDLE, GET_A, GET_B, GET_OP, SEND_RES, SEND_FLAGS.
  - IDLE: 0xCD -> GET_A. 0xD1 -> SEND_RES. Any other byte is ignored.
  - GET_A/GET_B/GET_OP latch each received byte in turn.
  - On the op byte, result and flags are registered in the same cycle, LEDS updates, then -> IDLE.
  - SEND_RES sends the result byte, waits !tx_busy, then SEND_FLAGS sends the flags byte and -> IDLE.
  - Bytes that arrive while in SEND_* are ignored.
- ALU: combinational, 8-bit, opcodes MIPS funct style:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x02 SRL (A>>B[2:0]), 0x03 SRA (arithmetic A>>>B[2:0]).
  - Undefined opcode: result 0x00, flags 0x00.
- Flags byte = {4'b0, N, V, C, Z}:
  - Z: result==0.
  - C: ADD carry out; SUB borrow (A<B unsigned). 0 for all other ops.
  - V: signed overflow, ADD/SUB only.
  - N: result[7].
- DISPLAY before any CONFIG returns 0x00, 0x00.

Decomposition:
- Shared package tp2_pkg: CMD_CONFIG=8'hCD, CMD_DISPLAY=8'hD1, the opcode constants, flag bit indices, and the command-FSM state enum.
- One natural sub-module, tp2_uart: baud generator + RX + TX. Interface: rx_data/rx_valid, tx_data/tx_start/tx_busy.
- ALU and command FSM stay in tp2_top.

Test Plan:
- Reset held, then released: TX_OUT=1, LEDS=0x00; DISPLAY -> TX bytes 0x00, 0x00.
- CD,05,0A,20 then D1 -> LEDS=0x0F; TX 0x0F then flags 0x00.
- CD,64,64,22 then D1 -> LEDS=0x00; TX 0x00, flags 0x01 (Z).
- CD,64,32,20 then D1 -> LEDS=0x96; TX 0x96, flags 0x0C (V,N).
- CD,03,05,22 -> result 0xFE, flags 0x0A (C,N). CD,F0,02,03 -> result 0xFC. Unknown opcode 0x3F -> result 0, flags 0.
- Robustness:
  - Byte 0x55 in IDLE: no response.
  - Frame with stop=0 during GET_A: dropped; the next good byte becomes A.
  - Reset mid-TX: TX_OUT returns to 1 immediately.
  - 100 ns low glitch on RX_IN: no byte received.
